// File: rtl/n64_deblur_est.sv
// n64_deblur_est
//   Estimates whether the N64 is outputting its blurred (horizontally
//   filtered) picture and decides once per frame whether deblur is applied.
//   The raw VDATA bus is decoded here: a sync word (nDSYNC low) is followed by
//   R, G and B data cycles. Consecutive pixel pairs are compared; a pair whose
//   gradients invert in enough channels counts as a "sharp" hit. A frame with a
//   saturated hit counter pushes a trend counter up, otherwise down, and the
//   trend is turned into a verdict through hysteresis thresholds.
//
// Ports
//   VCLK          video clock
//   nRST          asynchronous active-low reset
//   nDSYNC        low marks a sync-word cycle on D_i
//   D_i           VDATA: sync word (bit3 nVSYNC, bit0 nCSYNC) or one colour
//   vmode         line phase selector; blur_pix reloads to ~vmode on nCSYNC rise
//   n64_480i      interlaced mode, suspends estimation
//   nForceDeBlur  1 = automatic decision, 0 = manual decision
//   nDeBlurMan    manual setting (0 = deblur)
//   ndo_deblur    0 = apply deblur; changes only at frame boundaries
//   nblur_est     raw hysteresis estimate (1 = N64 blur off)
//   trend_o       current trend counter value
//   est_valid     at least one frame evaluated since reset / 480i exit
module n64_deblur_est #(
    parameter int COLOR_W    = 7,
    parameter int CMP_BITS   = 3,
    parameter int CNT_W      = 2,
    parameter int CH_MIN     = 2,
    parameter int TREND_W    = 9,
    parameter int TH_HI      = 2**(TREND_W-1),
    parameter int TH_LO      = 2**(TREND_W-1) - 1,
    parameter int FRAME_SKIP = 1
) (
    input  logic               VCLK,
    input  logic               nRST,
    input  logic               nDSYNC,
    input  logic [COLOR_W-1:0] D_i,
    input  logic               vmode,
    input  logic               n64_480i,
    input  logic               nForceDeBlur,
    input  logic               nDeBlurMan,
    output logic               ndo_deblur,
    output logic               nblur_est,
    output logic [TREND_W-1:0] trend_o,
    output logic               est_valid
);

    localparam logic [TREND_W-1:0] TREND_INIT = TREND_W'(2**(TREND_W-1));
    localparam logic [TREND_W-1:0] TREND_MAX  = '1;
    localparam logic [TREND_W-1:0] TH_HI_V    = TREND_W'(TH_HI);
    localparam logic [TREND_W-1:0] TH_LO_V    = TREND_W'(TH_LO);
    localparam logic [3:0]         SKIP_V     = 4'(FRAME_SKIP);
    localparam logic [1:0]         CH_MIN_V   = 2'(CH_MIN);

    logic [1:0]          phase;       // 1=R, 2=G, 3=B, 0=idle
    logic [3:0]          sync_reg;
    logic                blur_pix;    // 1: first pixel of a pair, 0: second
    logic [CMP_BITS-1:0] prev_val [3];
    logic [1:0]          grad     [3];
    logic [2:0]          chg;
    logic [CNT_W-1:0]    hit_cnt;
    logic [3:0]          skip_cnt;
    logic [TREND_W-1:0]  trend;

    logic [CMP_BITS-1:0] cur;
    logic [CMP_BITS-1:0] prev_sel;
    logic [1:0]          grad_sel;
    logic [1:0]          g_now;
    logic                chg_now;
    logic [1:0]          chg_cnt;
    logic                vs_fall;
    logic                cs_rise;
    logic                data_cyc;
    logic                hit;
    logic                est_upd;
    logic [TREND_W-1:0]  trend_n;
    logic                nblur_next;
    logic [1:0]          sync_unused;

    assign cur         = D_i[COLOR_W-1 -: CMP_BITS];
    assign vs_fall     = !nDSYNC &  sync_reg[3] & !D_i[3];
    assign cs_rise     = !nDSYNC & !sync_reg[0] &  D_i[0];
    assign data_cyc    = nDSYNC & (phase != 2'd0);
    assign sync_unused = sync_reg[2:1];
    assign trend_o     = trend;

    // Select the stored state of the channel arriving this cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        prev_sel = '0;
        grad_sel = '0;
        case (phase)
            2'd1: begin prev_sel = prev_val[0]; grad_sel = grad[0]; end
            2'd2: begin prev_sel = prev_val[1]; grad_sel = grad[1]; end
            2'd3: begin prev_sel = prev_val[2]; grad_sel = grad[2]; end
            default: ;
        endcase
    end

    // g = {rising, falling}; an inversion is one pixel rising where the
    // partner pixel fell (or vice versa), i.e. both bits differ.
    assign g_now   = {prev_sel < cur, prev_sel > cur};
    assign chg_now = (grad_sel ^ g_now) == 2'b11;
    // B's result joins the count combinationally so the last pair of a
    // frame is counted before the next sync cycle.
    assign chg_cnt = 2'(chg[0]) + 2'(chg[1]) + 2'(chg_now);
    assign hit     = data_cyc & (phase == 2'd3) & !blur_pix & (chg_cnt >= CH_MIN_V);

    assign est_upd = vs_fall & !n64_480i & (skip_cnt >= SKIP_V);

    always_comb begin
        trend_n    = trend;
        nblur_next = nblur_est;
        if (&hit_cnt) begin
            if (trend != TREND_MAX) trend_n = trend + 1'b1;
        end else begin
            if (trend != '0) trend_n = trend - 1'b1;
        end
        if (est_upd) begin
            if (trend_n >= TH_HI_V)      nblur_next = 1'b1;
            else if (trend_n <= TH_LO_V) nblur_next = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
            phase      <= 2'd0;
            sync_reg   <= 4'd0;
            blur_pix   <= 1'b0;
            // NOTE: the per-channel arrays are tiny and must start from a known
            // comparison baseline, so they are reset like ordinary registers.
            for (int c = 0; c < 3; c++) begin
                prev_val[c] <= '0;
                grad[c]     <= 2'b00;
            end
            chg        <= 3'b000;
            hit_cnt    <= '0;
            skip_cnt   <= 4'd0;
            trend      <= TREND_INIT;
            nblur_est  <= 1'b1;
            est_valid  <= 1'b0;
            ndo_deblur <= 1'b1;
        end else begin
            if (!nDSYNC) begin
                phase    <= 2'd1;
                sync_reg <= D_i[3:0];
                blur_pix <= cs_rise ? ~vmode : ~blur_pix;
            end else if (phase != 2'd0) begin
                phase <= phase + 2'd1;   // 3 wraps to 0 and holds there
                for (int c = 0; c < 3; c++) begin
                    if (phase == 2'(c + 1)) begin
                        prev_val[c] <= cur;
                        if (blur_pix) grad[c] <= g_now;
                        else          chg[c]  <= chg_now;
                    end
                end
                if (hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
            end

            if (vs_fall) begin
                if (!n64_480i) begin
                    if (skip_cnt < SKIP_V) begin
                        skip_cnt <= skip_cnt + 4'd1;
                    end else begin
                        trend     <= trend_n;
                        nblur_est <= nblur_next;
                        est_valid <= 1'b1;
                    end
                end
                hit_cnt    <= '0;
                ndo_deblur <= n64_480i | (nForceDeBlur ? nblur_next : nDeBlurMan);
            end

            // Interlaced video suspends estimation and restarts the skip window.
            if (n64_480i) begin
                skip_cnt  <= 4'd0;
                est_valid <= 1'b0;
                hit_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_n64_deblur_est.sv
module tb_n64_deblur_est;

    localparam int SKIP     = 1;
    localparam int HIT_FULL = 3;

    logic       VCLK = 1'b0;
    logic       nRST = 1'b1;
    logic       nDSYNC = 1'b1;
    logic [6:0] D_i = '0;
    logic       vmode = 1'b0;
    logic       n64_480i = 1'b0;
    logic       nForceDeBlur = 1'b1;
    logic       nDeBlurMan = 1'b1;

    logic       ndo0, ndo1, ndo2, nbe0, nbe1, nbe2, est0, est1, est2;
    logic [8:0] tr0, tr1;
    logic [3:0] tr2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 VCLK = ~VCLK;

    n64_deblur_est dut0 (
        .VCLK(VCLK), .nRST(nRST), .nDSYNC(nDSYNC), .D_i(D_i), .vmode(vmode),
        .n64_480i(n64_480i), .nForceDeBlur(nForceDeBlur), .nDeBlurMan(nDeBlurMan),
        .ndo_deblur(ndo0), .nblur_est(nbe0), .trend_o(tr0), .est_valid(est0));

    n64_deblur_est #(.TH_HI(260), .TH_LO(252)) dut1 (
        .VCLK(VCLK), .nRST(nRST), .nDSYNC(nDSYNC), .D_i(D_i), .vmode(vmode),
        .n64_480i(n64_480i), .nForceDeBlur(nForceDeBlur), .nDeBlurMan(nDeBlurMan),
        .ndo_deblur(ndo1), .nblur_est(nbe1), .trend_o(tr1), .est_valid(est1));

    n64_deblur_est #(.TREND_W(4)) dut2 (
        .VCLK(VCLK), .nRST(nRST), .nDSYNC(nDSYNC), .D_i(D_i), .vmode(vmode),
        .n64_480i(n64_480i), .nForceDeBlur(nForceDeBlur), .nDeBlurMan(nDeBlurMan),
        .ndo_deblur(ndo2), .nblur_est(nbe2), .trend_o(tr2), .est_valid(est2));

    // Reference model: pixel-level, gradients as signs (+1 up, -1 down, 0 flat).
    logic [3:0] m_sync;
    logic       m_blur;
    int         m_prev [3];
    int         m_gs   [3];
    int         m_opp  [3];
    int         m_hit, m_skip, m_pix;
    int         m_trend [3];
    logic       m_nbe [3];
    logic       m_ndo [3];
    logic       m_est [3];
    int         m_max [3] = '{511, 511, 15};
    int         m_hi  [3] = '{256, 260, 8};
    int         m_lo  [3] = '{255, 252, 7};

    function automatic logic [11:0] exp_vec(input int k);
        return {m_ndo[k], m_nbe[k], m_est[k], 9'(m_trend[k])};
    endfunction

    function automatic logic [11:0] act_vec(input int k);
        case (k)
            0:       return {ndo0, nbe0, est0, tr0};
            1:       return {ndo1, nbe1, est1, tr1};
            default: return {ndo2, nbe2, est2, 5'b0, tr2};
        endcase
    endfunction

    task automatic model_reset();
        m_sync = '0; m_blur = 1'b0; m_hit = 0; m_skip = 0;
        for (int k = 0; k < 3; k++) begin
            m_prev[k] = 0; m_gs[k] = 0; m_opp[k] = 0;
            m_trend[k] = (m_max[k] + 1) / 2;
            m_nbe[k] = 1'b1; m_ndo[k] = 1'b1; m_est[k] = 1'b0;
        end
    endtask

    task automatic model_sync(input logic [3:0] s);
        bit vs, cs;
        int t;
        vs = m_sync[3] && !s[3];
        cs = !m_sync[0] && s[0];
        if (vs) begin
            if (!n64_480i) begin
                if (m_skip < SKIP) m_skip++;
                else begin
                    for (int k = 0; k < 3; k++) begin
                        t = (m_hit == HIT_FULL) ? m_trend[k] + 1 : m_trend[k] - 1;
                        if (t < 0) t = 0;
                        if (t > m_max[k]) t = m_max[k];
                        m_trend[k] = t;
                        if (t >= m_hi[k]) m_nbe[k] = 1'b1;
                        else if (t <= m_lo[k]) m_nbe[k] = 1'b0;
                        m_est[k] = 1'b1;
                    end
                end
            end
            for (int k = 0; k < 3; k++)
                m_ndo[k] = n64_480i | (nForceDeBlur ? m_nbe[k] : nDeBlurMan);
            m_hit = 0;
        end
        if (n64_480i) begin
            m_skip = 0; m_hit = 0;
            for (int k = 0; k < 3; k++) m_est[k] = 1'b0;
        end
        m_blur = cs ? !vmode : !m_blur;
        m_sync = s;
    endtask

    task automatic model_data(input int c, input int v);
        int cur, s;
        cur = v >> 4;
        s = (cur > m_prev[c]) ? 1 : (cur < m_prev[c]) ? -1 : 0;
        if (m_blur) m_gs[c] = s;
        else        m_opp[c] = (m_gs[c] * s == -1) ? 1 : 0;
        m_prev[c] = cur;
        if (c == 2 && !m_blur && (m_opp[0] + m_opp[1] + m_opp[2]) >= 2 && m_hit < HIT_FULL)
            m_hit++;
        if (n64_480i) m_hit = 0;
    endtask

    task automatic cyc(input logic nd, input logic [6:0] d);
        @(negedge VCLK);
        nDSYNC = nd;
        D_i    = d;
    endtask

    task automatic send_pixel(input logic nvs, input logic ncs, input int r, input int g, input int b);
        logic [3:0] s;
        s = {nvs, 2'b00, ncs};
        model_sync(s);   cyc(1'b0, {3'b000, s});
        model_data(0, r); cyc(1'b1, 7'(r));
        model_data(1, g); cyc(1'b1, 7'(g));
        model_data(2, b); cyc(1'b1, 7'(b));
        m_pix++;
    endtask

    // kind 0 = flat grey, 1 = sharp stripes, 2 = random. Content pixels, then
    // the vsync pixel that closes the frame.
    task automatic send_frame(input int kind, input int npix, input bit rnd_cs);
        for (int p = 0; p <= npix; p++) begin
            int r, g, b;
            logic ncs;
            case (kind)
                0: begin r = 64; g = 64; b = 64; end
                1: begin r = (m_pix % 2 != 0) ? 127 : 0; g = r; b = r; end
                default: begin
                    r = int'($urandom_range(0, 127));
                    g = int'($urandom_range(0, 127));
                    b = int'($urandom_range(0, 127));
                end
            endcase
            ncs = rnd_cs ? 1'($urandom_range(0, 1)) : 1'((m_pix / 4) % 2);
            send_pixel((p == npix) ? 1'b0 : 1'b1, ncs, r, g, b);
        end
    endtask

    task automatic set_ctrl(input logic f, input logic m, input logic i, input logic vm);
        @(negedge VCLK);
        nDSYNC = 1'b1;
        nForceDeBlur = f; nDeBlurMan = m; n64_480i = i; vmode = vm;
        if (i) begin
            m_hit = 0; m_skip = 0;
            for (int k = 0; k < 3; k++) m_est[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        #1 nRST = 1'b0;
        #11;
        n_checks++; if ({ndo0, nbe0, est0} !== 3'b110) $display("FAIL reset_flags: got %b expected 110", {ndo0, nbe0, est0}); else n_pass++;
        n_checks++; if (tr0 !== 9'h100) $display("FAIL reset_trend0: got %h expected 100", tr0); else n_pass++;
        n_checks++; if (tr2 !== 4'h8) $display("FAIL reset_trend2: got %h expected 8", tr2); else n_pass++;
        @(negedge VCLK);
        nRST = 1'b1;
        model_reset();
        m_pix = 0;
    endtask

    task automatic test_flat();
        send_frame(0, 12, 1'b0);
        n_checks++; if ({tr0, est0} !== {9'h100, 1'b0}) $display("FAIL flat_skip: got %h/%b expected 100/0", tr0, est0); else n_pass++;
        send_frame(0, 12, 1'b0);
        n_checks++; if ({tr0, nbe0, ndo0, est0} !== {9'h0FF, 3'b001}) $display("FAIL flat_second: got %h/%b%b%b expected 0ff/001", tr0, nbe0, ndo0, est0); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (act_vec(k) !== exp_vec(k)) $display("FAIL flat_model dut%0d: got %h expected %h", k, act_vec(k), exp_vec(k)); else n_pass++;
        end
    endtask

    task automatic test_stripes();
        send_frame(1, 12, 1'b0);
        n_checks++; if ({tr0, nbe0, ndo0} !== {9'h100, 2'b11}) $display("FAIL stripes_cross: got %h/%b%b expected 100/11", tr0, nbe0, ndo0); else n_pass++;
        send_frame(1, 12, 1'b0);
        n_checks++; if (tr0 !== 9'h101) $display("FAIL stripes_second: got %h expected 101", tr0); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (act_vec(k) !== exp_vec(k)) $display("FAIL stripes_model dut%0d: got %h expected %h", k, act_vec(k), exp_vec(k)); else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        for (int p = 0; p < 8; p++) send_pixel(1'b1, 1'b1, (p % 2 != 0) ? 127 : 0, 0, 127);
        #2 nRST = 1'b0;
        #1;
        n_checks++; if ({ndo0, nbe0, est0, tr0} !== {3'b110, 9'h100}) $display("FAIL midreset_dut0: got %b%b%b/%h expected 110/100", ndo0, nbe0, est0, tr0); else n_pass++;
        n_checks++; if ({est1, tr1, tr2} !== {1'b0, 9'h100, 4'h8}) $display("FAIL midreset_others: got %b/%h/%h expected 0/100/8", est1, tr1, tr2); else n_pass++;
        @(negedge VCLK);
        nDSYNC = 1'b1;
        @(negedge VCLK);
        nRST = 1'b1;
        model_reset();
    endtask

    task automatic test_hysteresis();
        send_frame(0, 12, 1'b0);
        n_checks++; if ({tr1, est1} !== {9'h100, 1'b0}) $display("FAIL hyst_skip: got %h/%b expected 100/0", tr1, est1); else n_pass++;
        for (int f = 0; f < 3; f++) send_frame(1, 12, 1'b0);
        n_checks++; if ({tr1, nbe1} !== {9'h103, 1'b1}) $display("FAIL hyst_up: got %h/%b expected 103/1", tr1, nbe1); else n_pass++;
        for (int f = 0; f < 5; f++) send_frame(0, 12, 1'b0);
        n_checks++; if ({tr1, nbe1} !== {9'h0FE, 1'b1}) $display("FAIL hyst_hold: got %h/%b expected 0fe/1", tr1, nbe1); else n_pass++;
        send_frame(0, 12, 1'b0);
        n_checks++; if ({tr1, nbe1} !== {9'h0FD, 1'b1}) $display("FAIL hyst_fd: got %h/%b expected 0fd/1", tr1, nbe1); else n_pass++;
        send_frame(0, 12, 1'b0);
        n_checks++; if ({tr1, nbe1} !== {9'h0FC, 1'b0}) $display("FAIL hyst_low: got %h/%b expected 0fc/0", tr1, nbe1); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (act_vec(k) !== exp_vec(k)) $display("FAIL hyst_model dut%0d: got %h expected %h", k, act_vec(k), exp_vec(k)); else n_pass++;
        end
    endtask

    task automatic test_480i();
        int held;
        held = m_trend[0];
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(1, 12, 1'b0);
        n_checks++; if ({ndo0, est0, tr0} !== {2'b10, 9'(held)}) $display("FAIL i480_on: got %b%b/%h expected 10/%h", ndo0, est0, tr0, 9'(held)); else n_pass++;
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(1, 12, 1'b0);
        n_checks++; if ({est0, tr0} !== {1'b0, 9'(held)}) $display("FAIL i480_skip: got %b/%h expected 0/%h", est0, tr0, 9'(held)); else n_pass++;
        send_frame(1, 12, 1'b0);
        n_checks++; if (est0 !== 1'b1) $display("FAIL i480_resume: got %b expected 1", est0); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (act_vec(k) !== exp_vec(k)) $display("FAIL i480_model dut%0d: got %h expected %h", k, act_vec(k), exp_vec(k)); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        for (int f = 0; f < 20; f++) send_frame(1, 12, 1'b0);
        n_checks++; if ({tr2, nbe2} !== {4'hF, 1'b1}) $display("FAIL sat_trend2: got %h/%b expected f/1", tr2, nbe2); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (act_vec(k) !== exp_vec(k)) $display("FAIL sat_model dut%0d: got %h expected %h", k, act_vec(k), exp_vec(k)); else n_pass++;
        end
    endtask

    task automatic test_manual();
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8, 1'b0);
        n_checks++; if ({ndo0, ndo2, nbe0} !== 3'b001) $display("FAIL manual_on: got %b%b%b expected 001", ndo0, ndo2, nbe0); else n_pass++;
        set_ctrl(1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(0, 8, 1'b0);
        n_checks++; if ({ndo0, ndo1, ndo2} !== 3'b111) $display("FAIL manual_off: got %b%b%b expected 111", ndo0, ndo1, ndo2); else n_pass++;
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            set_ctrl(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
            send_frame(int'($urandom_range(0, 2)), int'($urandom_range(4, 14)), 1'b1);
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (act_vec(k) !== exp_vec(k))
                    $display("FAIL random_f%0d dut%0d: got %h expected %h", f, k, act_vec(k), exp_vec(k));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_stripes();
        test_mid_reset();
        test_hysteresis();
        test_480i();
        test_saturation();
        test_manual();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/n64_deblur_est.md
# n64_deblur_est

Parametrised blur estimator and deblur-decision block for the N64 video input path, placed between the VDATA demux stage and the pixel-doubling/blanking logic. It decodes the N64 sync word and RGB phases from the raw VDATA bus itself. It builds per-channel gradient statistics over candidate blurry pixel pairs and filters the per-frame verdict through a saturating trend counter with hysteresis thresholds. Once per frame it outputs the deblur decision and status for the OSD/controller.

## Interface
Parameters:
- COLOR_W, 7, width of VDATA bus D_i, which carries one colour channel per data cycle.
- CMP_BITS, 3, number of colour MSBs used for gradient comparison (1..COLOR_W).
- CNT_W, 2, width of per-frame hit counter; a frame counts as "sharp" when the counter saturates.
- CH_MIN, 2, minimum number of channels (1..3) with an inverted gradient for a pixel pair to count as a hit.
- TREND_W, 9, trend counter width.
- TH_HI, 2^(TREND_W-1), trend value at or above which blur is estimated off.
- TH_LO, 2^(TREND_W-1)-1, trend value at or below which blur is estimated on. TH_LO < TH_HI is required.
- FRAME_SKIP, 1, frame boundaries ignored after reset or after leaving 480i before estimation runs (0..15).

Ports:
- VCLK, in, 1, video clock.
- nRST, in, 1, asynchronous active-low reset.
- nDSYNC, in, 1, low marks a sync-word cycle on D_i.
- D_i, in, COLOR_W, VDATA. In a sync cycle: bit3 = nVSYNC, bit0 = nCSYNC. Otherwise the bus carries R, G, B in consecutive cycles.
- vmode, in, 1, line phase selector; blur_pix reloads to ~vmode on a rising edge of nCSYNC.
- n64_480i, in, 1, interlaced mode; when high, estimation is suspended.
- nForceDeBlur, in, 1, 1 = automatic estimation, 0 = manual.
- nDeBlurMan, in, 1, manual setting (0 = deblur).
- ndo_deblur, out, 1, 0 = apply deblur; updated only at frame boundaries.
- nblur_est, out, 1, raw hysteresis estimate (1 = N64 blur off).
- trend_o, out, TREND_W, current trend value.
- est_valid, out, 1, high once at least one frame has been evaluated since the last reset or 480i exit.

## Operation
- **Phase counter (2 bits):** reloads to 1 after a cycle with nDSYNC low. Otherwise it steps 1→2→3→0 and holds at 0. R is captured at phase 1, G at phase 2, B at phase 3. Data arriving at phase 0 is ignored.
- **Sync register (4 bits):** loads D_i[3:0] in each nDSYNC-low cycle.
  - vs_fall = sync_reg[3] & !D_i[3], qualified by nDSYNC low.
  - cs_rise = !sync_reg[0] & D_i[0], qualified by nDSYNC low.
- **blur_pix:** updated in each sync cycle. It loads ~vmode if cs_rise is set; otherwise it toggles.
- **Gradient per channel c:** compare the top CMP_BITS of the current channel value against the stored previous value of the same channel. The result is g = {prev<cur, prev>cur}. The previous value is then overwritten with the current value every data cycle.
  - If blur_pix = 1, store grad[c] = g.
  - If blur_pix = 0, set chg[c] = (grad[c] ^ g) == 2'b11.
- **Hit evaluation:** at phase 3 with blur_pix = 0, the chg count includes the B result computed in the same cycle. If that count is ≥ CH_MIN, hit_cnt increments, saturating at all-ones.
- **Frame boundary** (vs_fall, n64_480i = 0):
  - If skip_cnt < FRAME_SKIP, increment skip_cnt and leave the trend untouched.
  - Otherwise:
    - trend_n = trend+1 if hit_cnt is all-ones, else trend-1; saturate at 2^TREND_W-1 and at 0.
    - trend ← trend_n.
    - nblur_est ← 1 if trend_n ≥ TH_HI, 0 if trend_n ≤ TH_LO, else hold.
    - est_valid ← 1.
  - In all cases, hit_cnt ← 0.
- **ndo_deblur at every vs_fall (regardless of n64_480i):**
  - If nForceDeBlur = 1: n64_480i | nblur_est_next, where nblur_est_next is the value being written in the same cycle.
  - If nForceDeBlur = 0: n64_480i | nDeBlurMan.
- **n64_480i = 1:** skip_cnt ← 0, est_valid ← 0, hit_cnt ← 0. trend and nblur_est hold.
- **Reset values:**
  - ndo_deblur = 1, nblur_est = 1, est_valid = 0.
  - trend_o = 2^(TREND_W-1).
  - hit_cnt, skip_cnt, phase, sync_reg, grad, chg and previous values all 0.
  - blur_pix = 0.

## Timing
- All state updates on the rising edge of VCLK. nRST acts immediately and overrides everything; a mid-frame reset discards the partial hit_cnt.
- ndo_deblur, nblur_est, trend_o and est_valid change on the edge that ends the vs_fall sync cycle. They are visible from the next cycle and are stable for the rest of the frame.
- A hit from the final pixel pair of a frame is counted, because phase-3 evaluation always precedes the next sync cycle.
- vs_fall and cs_rise in the same cycle are both processed.
- Phase is not advanced by back-to-back nDSYNC-low cycles; it stays at 1.

## Test plan
- **Reset:** assert nRST mid-frame → ndo_deblur = 1, nblur_est = 1, trend_o = 0x100, est_valid = 0 immediately, without waiting for a VCLK edge.
- **Flat grey frames with defaults:**
  - The 1st vs_fall is skipped (trend 0x100, est_valid 0).
  - The 2nd gives trend 0xFF, nblur_est 0, and ndo_deblur 0 with nForceDeBlur = 1.
- **Alternating sharp stripes** (R/G/B toggling 0x00/0x7F per pixel): hit_cnt saturates each frame. Starting from 0xFF, 2 frames give trend 0x101 and nblur_est 1 at the first crossing (trend 0x100 ≥ TH_HI).
- **Hysteresis:** with TH_HI = 0x104 and TH_LO = 0xFC, starting from 0x100, 3 sharp frames leave nblur_est unchanged at 1. After 5 flat frames (trend 0xFE) it still holds; it goes to 0 only at trend 0xFC.
- **480i:** raise n64_480i → at next vs_fall ndo_deblur = 1 and est_valid = 0, with trend held. Lower it → the first frame is skipped, and est_valid rises at the second vs_fall.
- **Saturation and manual mode:** with TREND_W = 4, 20 sharp frames → trend_o = 0xF with no wrap. With nForceDeBlur = 0 and nDeBlurMan = 0, ndo_deblur = 0 at the next vs_fall independent of trend.
